// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: size encodings, FSM states
// and the default base address.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [31:0] DMEM_BASE = 32'h0100_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request-response bus between the core memory stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_write, req_size, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_size, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_word_ram.sv
// Word-organised RAM with per-byte write enables and an asynchronous read of
// the addressed word. Contents are not affected by reset.
module dmem_word_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned IdxW = $clog2(DEPTH_WORDS)
) (
    input  logic            clock,
    input  logic [IdxW-1:0] idx_i,
    input  logic            we_i,
    input  logic [3:0]      be_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     rdata_o
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i && be_i[b]) begin
                mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: decodes byte/half/word accesses, checks alignment
// and range, and answers after a fixed programmable latency.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int unsigned IdxW  = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LatM1 = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic            in_idle;
    logic [31:0]     cur_addr, cur_wdata, offset;
    logic            cur_write;
    logic [1:0]      cur_size, lane;
    logic [IdxW-1:0] idx;
    logic            acc_err, enter_resp, ram_we;
    logic [3:0]      ram_be;
    logic [31:0]     ram_wdata, ram_rdata, shifted, load_data;

    // With LATENCY==1 the access completes straight out of IDLE, so decode
    // must look at the live request rather than the captured copy.
    assign in_idle   = (state_q == IDLE);
    assign cur_addr  = in_idle ? bus.req_addr  : addr_q;
    assign cur_write = in_idle ? bus.req_write : write_q;
    assign cur_size  = in_idle ? bus.req_size  : size_q;
    assign cur_wdata = in_idle ? bus.req_wdata : wdata_q;

    // Addresses below the base wrap to a huge offset and fail the range test.
    assign offset = cur_addr - BASE_ADDR;
    assign lane   = offset[1:0];
    assign idx    = offset[IdxW+1:2];

    always_comb begin
        acc_err = ((offset >> (IdxW + 2)) != 32'd0);
        unique case (cur_size)
            SZ_BYTE: ;
            SZ_HALF: if (lane[0]) acc_err = 1'b1;
            SZ_WORD: if (lane != 2'd0) acc_err = 1'b1;
            default: acc_err = 1'b1;
        endcase
    end

    always_comb begin
        ram_be    = 4'hF;
        ram_wdata = cur_wdata;
        unique case (cur_size)
            SZ_BYTE: begin
                ram_be    = 4'b0001 << lane;
                ram_wdata = {4{cur_wdata[7:0]}};
            end
            SZ_HALF: begin
                ram_be    = 4'b0011 << lane;
                ram_wdata = {2{cur_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = ram_rdata >> {lane, 3'b000};

    always_comb begin
        unique case (cur_size)
            SZ_BYTE: load_data = shifted & 32'h0000_00FF;
            SZ_HALF: load_data = shifted & 32'h0000_FFFF;
            default: load_data = ram_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        write_d     = write_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        enter_resp  = 1'b0;
        ram_we      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d      = bus.req_addr;
                    write_d     = bus.req_write;
                    size_d      = bus.req_size;
                    wdata_d     = bus.req_wdata;
                    cnt_d       = LatM1;
                    req_ready_d = 1'b0;
                    if (LATENCY == 1) enter_resp = 1'b1;
                    else state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) enter_resp = 1'b1;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err || cur_write) ? 32'd0 : load_data;
            // Reset wins over a commit landing on the same edge.
            ram_we      = cur_write && !acc_err && !reset;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            write_q     <= 1'b0;
            size_q      <= 2'd0;
            wdata_q     <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    dmem_word_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clock  (clock),
        .idx_i  (idx),
        .we_i   (ram_we),
        .be_i   (ram_be),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: loads, stores, faults, range edge,
// response backpressure and reset during a pending store.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam logic [31:0] TOP  = BASE + 32'd4096;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    dmem_responder_if bus ();

    dmem_responder #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(1024),
        .LATENCY    (2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Issue one request and take its response; lat counts negedges from accept.
    task automatic xact(input logic [31:0] a, input logic w, input logic [1:0] s,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic e, output int lat);
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_write = w;
        bus.req_size  = s;
        bus.req_wdata = wd;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        rd = bus.rsp_rdata;
        e  = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'd0 ||
            bus.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b vld=%b rd=%h err=%b want 1 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd;
        logic e;
        int lat;
        xact(BASE + 32'h10, 1'b1, 2'd2, 32'hDEAD_BEEF, rd, e, lat);
        checks++;
        if (lat !== 2 || rd !== 32'd0 || e !== 1'b0) begin
            failures++;
            $display("FAIL word_store: got lat=%0d rd=%h err=%b want 2 0 0", lat, rd, e);
        end
        xact(BASE + 32'h10, 1'b0, 2'd2, 32'd0, rd, e, lat);
        checks++;
        if (lat !== 2 || rd !== 32'hDEAD_BEEF || e !== 1'b0) begin
            failures++;
            $display("FAIL word_load: got lat=%0d rd=%h err=%b want 2 deadbeef 0", lat, rd, e);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd;
        logic e;
        int lat;
        xact(BASE + 32'h13, 1'b1, 2'd0, 32'hFFFF_FF5A, rd, e, lat);
        xact(BASE + 32'h10, 1'b0, 2'd2, 32'd0, rd, e, lat);
        checks++;
        if (rd !== 32'h5AAD_BEEF || e !== 1'b0) begin
            failures++;
            $display("FAIL byte_merge: got rd=%h err=%b want 5aadbeef 0", rd, e);
        end
        xact(BASE + 32'h13, 1'b0, 2'd0, 32'd0, rd, e, lat);
        checks++;
        if (rd !== 32'h0000_005A || e !== 1'b0) begin
            failures++;
            $display("FAIL byte_load_lane3: got rd=%h err=%b want 0000005a 0", rd, e);
        end
        xact(BASE + 32'h11, 1'b0, 2'd0, 32'd0, rd, e, lat);
        checks++;
        if (rd !== 32'h0000_00BE || e !== 1'b0) begin
            failures++;
            $display("FAIL byte_load_lane1: got rd=%h err=%b want 000000be 0", rd, e);
        end
        xact(BASE + 32'h12, 1'b0, 2'd1, 32'd0, rd, e, lat);
        checks++;
        if (rd !== 32'h0000_5AAD || e !== 1'b0) begin
            failures++;
            $display("FAIL half_load: got rd=%h err=%b want 00005aad 0", rd, e);
        end
        xact(BASE + 32'h10, 1'b1, 2'd1, 32'hAAAA_1234, rd, e, lat);
        xact(BASE + 32'h10, 1'b0, 2'd2, 32'd0, rd, e, lat);
        checks++;
        if (rd !== 32'h5AAD_1234 || e !== 1'b0) begin
            failures++;
            $display("FAIL half_store: got rd=%h err=%b want 5aad1234 0", rd, e);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic e;
        int lat;
        logic [31:0] addrs [4] = '{BASE + 32'h11, BASE + 32'h2, BASE + 32'h10, 32'h00FF_FFFC};
        logic        wr    [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [1:0]  sz    [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
        for (int i = 0; i < 4; i++) begin
            xact(addrs[i], wr[i], sz[i], 32'h1111_1111, rd, e, lat);
            checks++;
            if (rd !== 32'd0 || e !== 1'b1) begin
                failures++;
                $display("FAIL err_case%0d: got rd=%h err=%b want 0 1", i, rd, e);
            end
        end
        xact(BASE + 32'h10, 1'b0, 2'd2, 32'd0, rd, e, lat);
        checks++;
        if (rd !== 32'h5AAD_1234 || e !== 1'b0) begin
            failures++;
            $display("FAIL err_no_write: got rd=%h err=%b want 5aad1234 0", rd, e);
        end
        xact(BASE, 1'b0, 2'd2, 32'd0, rd, e, lat);
        checks++;
        if (rd === 32'h1111_1111) begin
            failures++;
            $display("FAIL err_store_leak: got rd=%h want not 11111111", rd);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] rd;
        logic e;
        int lat;
        xact(TOP - 32'd1, 1'b1, 2'd0, 32'h0000_00A5, rd, e, lat);
        checks++;
        if (e !== 1'b0) begin
            failures++;
            $display("FAIL last_byte_store: got err=%b want 0", e);
        end
        xact(TOP - 32'd1, 1'b0, 2'd0, 32'd0, rd, e, lat);
        checks++;
        if (rd !== 32'h0000_00A5 || e !== 1'b0) begin
            failures++;
            $display("FAIL last_byte_load: got rd=%h err=%b want 000000a5 0", rd, e);
        end
        xact(TOP, 1'b1, 2'd0, 32'h0000_00A5, rd, e, lat);
        checks++;
        if (e !== 1'b1) begin
            failures++;
            $display("FAIL past_end_store: got err=%b want 1", e);
        end
        xact(TOP, 1'b0, 2'd0, 32'd0, rd, e, lat);
        checks++;
        if (rd !== 32'd0 || e !== 1'b1) begin
            failures++;
            $display("FAIL past_end_load: got rd=%h err=%b want 0 1", rd, e);
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_addr  = BASE + 32'h10;
        bus.req_write = 1'b0;
        bus.req_size  = 2'd2;
        @(posedge clock);
        @(negedge clock);
        // A second request held during the wait must be ignored.
        bus.req_write = 1'b1;
        bus.req_wdata = 32'h0BAD_0BAD;
        checks++;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_wait: got rdy=%b vld=%b want 0 0", bus.req_ready, bus.rsp_valid);
        end
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h5AAD_1234 ||
                bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: got vld=%b rd=%h err=%b rdy=%b want 1 5aad1234 0 0",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready);
            end
            @(negedge clock);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd;
        logic e;
        int lat;
        xact(BASE, 1'b1, 2'd2, 32'hCAFE_F00D, rd, e, lat);
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_addr  = BASE;
        bus.req_write = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_wdata = 32'h1234_5678;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'd0 ||
            bus.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_wait_state: got rdy=%b vld=%b rd=%h err=%b want 1 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        xact(BASE, 1'b0, 2'd2, 32'd0, rd, e, lat);
        checks++;
        if (rd !== 32'hCAFE_F00D || e !== 1'b0) begin
            failures++;
            $display("FAIL reset_wait_nocommit: got rd=%h err=%b want cafef00d 0", rd, e);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_write = 1'b0;
        bus.req_size  = 2'd0;
        bus.req_wdata = 32'd0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_word();
        test_byte_half();
        test_errors();
        test_boundary();
        test_backpressure();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the core's load/store port. Serves byte, half and word accesses from a little-endian word array.
- Uses a valid/ready request-response handshake with a programmable response latency, so the core's memory stage can be tested against non-zero-latency memory.
- Sits between the core's memory stage and on-chip data RAM.
- Returns load data right-aligned and zero-padded; sign extension remains the core's job.

Parameters:
- BASE_ADDR, 32'h01000000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
- LATENCY, 2, cycles from request acceptance to first rsp_valid cycle; legal range 1..15.

Ports:
- clock  input  1  clock, rising edge.
- reset  input  1  reset, synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  32  byte address.
- req_write  input  1  0 = load, 1 = store.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  32  load data, right-aligned, zero-padded; 0 for stores and errors.
- rsp_err  output  1  access faulted.

Behaviour:
- States: IDLE, WAIT, RESP. Reset forces IDLE. Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. The RAM array is not cleared by reset.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge: capture addr, write, size and wdata; load counter with LATENCY-1.
  - If LATENCY==1, go directly to RESP; otherwise go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; at the edge where the counter is 1, go to RESP.
  - Accept happens at edge T, so rsp_valid first goes high in the cycle after edge T+LATENCY-1.
- Entry edge into RESP:
  - Stores commit to RAM on this edge.
  - Load data and error are registered on this edge.
  - A load issued after a store's response always sees the stored data.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - Then go to IDLE. req_ready rises one cycle after the handshake; no back-to-back accept occurs in the same cycle.
- Single outstanding request. req_* inputs are ignored outside IDLE.
- Address decode:
  - offset = req_addr - BASE_ADDR (32-bit unsigned).
  - Word index = offset[log2(DEPTH_WORDS)+1:2]; byte lane = offset[1:0].
- Errors (rsp_err=1, no RAM write, rsp_rdata=0):
  - offset >= 4*DEPTH_WORDS, including addresses below BASE_ADDR, which wrap to a large offset;
  - size=3;
  - half with lane[0]=1;
  - word with lane != 0.
- Store byte enables:
  - byte: lane bit only, with data wdata[7:0] replicated to all lanes;
  - half: lanes {lane+1, lane}, with wdata[15:0] replicated;
  - word: all four lanes.
- Load data:
  - byte: word >> (8*lane), masked to 8 bits;
  - half: masked to 16 bits;
  - word: full word.
- The last address (4*DEPTH_WORDS-1, byte) is legal; the next address errors.
- Reset mid-operation (WAIT or RESP):
  - the transaction is dropped and the state goes to IDLE;
  - a store still in WAIT is not committed; a store already in RESP has committed.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - state enum (IDLE, WAIT, RESP);
  - DMEM_BASE=32'h01000000.
- One sub-module: dmem_word_ram, a synchronous word array with a 4-bit byte-enable write and a combinational read of the indexed word. It is instantiated once.
- Decode, alignment check, lane steering and the FSM stay in dmem_responder.

Test Plan:
- Reset, then word store of 32'hDEADBEEF to 32'h01000010, then word load of the same address with LATENCY=2.
  - Response: rsp_valid in the 2nd cycle after accept, rdata=32'hDEADBEEF, err=0.
- Byte store of 8'h5A to 32'h01000013, then word load of 32'h01000010.
  - Response: rdata=32'h5AADBEEF.
  - A byte load of 32'h01000013 returns 32'h0000005A.
- Half load from 32'h01000011, word store to 32'h01000002, access with size=3, and load from 32'h00FFFFFC.
  - Response: err=1 and rdata=0 for each.
  - A follow-up load of 32'h01000010 shows the memory unchanged.
- Boundary: byte store then load at BASE+4*DEPTH_WORDS-1 succeeds; the same access at BASE+4*DEPTH_WORDS returns err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_valid, rdata and err stay stable; req_ready stays 0.
  - After the handshake: rsp_valid=0 next cycle and req_ready=1.
- Reset asserted while in WAIT on a store of 32'h12345678 to BASE.
  - Outputs return to reset values.
  - A later load of BASE returns its pre-store contents.
